// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit: op codes,
// sequencer states and the default operand width.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic isArithOp(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic isSignedOp(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic isDivOp(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter_datapath.sv
// Iterative datapath: shift-add multiply and restoring divide sharing one
// 2*XLEN accumulator ({hi,lo} = product, or {remainder,quotient}).
module muldiv_iter_datapath
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            loadDiv,
  input  logic            signedOp,
  input  logic            step,
  input  logic            negRes,
  input  logic            negRem,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic [XLEN-1:0] resHi,
  output logic [XLEN-1:0] resLo
);

  localparam logic [XLEN-1:0]   ONE  = XLEN'(1);
  localparam logic [2*XLEN-1:0] ONE2 = (2*XLEN)'(1);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic              div_q, div_d;

  logic [XLEN-1:0]   magA, magB;
  logic [XLEN:0]     mulSum;
  logic [XLEN:0]     shlRem;
  logic [XLEN:0]     trial;
  logic [2*XLEN-1:0] mulNext, divNext;
  logic [2*XLEN-1:0] accNeg;
  logic [XLEN-1:0]   hiNeg, loNeg;

  // 32'h80000000 negates to itself, which is exactly its unsigned magnitude.
  assign magA = (signedOp && srcA[XLEN-1]) ? (~srcA + ONE) : srcA;
  assign magB = (signedOp && srcB[XLEN-1]) ? (~srcB + ONE) : srcB;

  assign mulSum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mulNext = {mulSum, acc_q[XLEN-1:1]};

  // The shifted remainder needs XLEN+1 bits so the trial subtract never wraps.
  assign shlRem  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign trial   = shlRem - {1'b0, opb_q};
  assign divNext = trial[XLEN] ? {shlRem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {trial[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

  always_comb begin
    acc_d = acc_q;
    opb_d = opb_q;
    div_d = div_q;
    if (load) begin
      div_d = loadDiv;
      acc_d = {{XLEN{1'b0}}, (loadDiv ? magA : magB)};
      opb_d = loadDiv ? magB : magA;
    end else if (step) begin
      acc_d = div_q ? divNext : mulNext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
      div_q <= div_d;
    end
  end

  assign accNeg = ~acc_q + ONE2;
  assign hiNeg  = ~acc_q[2*XLEN-1:XLEN] + ONE;
  assign loNeg  = ~acc_q[XLEN-1:0] + ONE;

  always_comb begin
    resHi = acc_q[2*XLEN-1:XLEN];
    resLo = acc_q[XLEN-1:0];
    if (div_q) begin
      if (negRes) resLo = loNeg;
      if (negRem) resHi = hiNeg;
    end else if (negRes) begin
      resHi = accNeg[2*XLEN-1:XLEN];
      resLo = accNeg[XLEN-1:0];
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multiply/divide sequencer owning HI/LO: FSM, iteration counter, sign
// flags and the decode stall for MFHI/MFLO or issue while busy.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int ITERS = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            read_req,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            negRes_q, negRes_d;
  logic            negRem_q, negRem_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            done_q, done_d;

  logic            dpLoad, dpStep;
  logic            opSigned, opDiv;
  logic [XLEN-1:0] resHi, resLo;

  assign opSigned = isSignedOp(op);
  assign opDiv    = isDivOp(op);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    negRes_d = negRes_q;
    negRem_d = negRem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dpLoad   = 1'b0;
    dpStep   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          if (isArithOp(op)) begin
            dpLoad   = 1'b1;
            // Divide by zero skips quotient fixup so lo stays all ones and hi
            // returns the dividend exactly as issued.
            negRes_d = opSigned && (src_a[XLEN-1] ^ src_b[XLEN-1])
                       && !(opDiv && (src_b == '0));
            negRem_d = opSigned && src_a[XLEN-1];
            count_d  = LAST;
            state_d  = RUN;
          end else if (op == MD_MTHI) begin
            hi_d = src_a;
          end else if (op == MD_MTLO) begin
            lo_d = src_a;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          dpStep  = 1'b1;
          count_d = count_q - 1'b1;
          if (count_q == '0) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          hi_d   = resHi;
          lo_d   = resLo;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      negRes_q <= 1'b0;
      negRem_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      negRes_q <= negRes_d;
      negRem_q <= negRem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  muldiv_iter_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (dpLoad),
    .loadDiv  (opDiv),
    .signedOp (opSigned),
    .step     (dpStep),
    .negRes   (negRes_q),
    .negRem   (negRem_q),
    .srcA     (src_a),
    .srcB     (src_b),
    .resHi    (resHi),
    .resLo    (resLo)
  );

  assign busy  = (state_q != IDLE);
  assign stall = busy && (read_req || start);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus randomized bench for muldiv_sequencer, checked against a
// plain-arithmetic reference of HI/LO results.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, readReq, flush;
  logic [2:0]  op;
  logic [31:0] srcA, srcB;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int nAsserts = 0;
  int nFail    = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32), .ITERS(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (srcA),
    .src_b    (srcB),
    .read_req (readReq),
    .flush    (flush),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    srcA  = a;
    srcB  = b;
  endtask

  // Returns {hi, lo} as the architecture defines them, using 64-bit arithmetic.
  function automatic logic [63:0] refModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      MD_MULT:  return sa * sb;
      MD_MULTU: return ua * ub;
      MD_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Issues one mul/div and checks busy span, exact done timing and the result.
  task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] expected;
    int busyCycles;
    int earlyDone;
    expected = refModel(o, a, b);
    applyStimulus(o, a, b);
    tick();
    start = 1'b0;
    checkOutput($sformatf("%s.doneClear", tag), done, 0);
    busyCycles = busy ? 1 : 0;
    earlyDone  = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (busy) busyCycles++;
      if (done) earlyDone++;
    end
    tick();
    checkOutput($sformatf("%s.busyCycles", tag), busyCycles, 33);
    checkOutput($sformatf("%s.earlyDone", tag), earlyDone, 0);
    checkOutput($sformatf("%s.done", tag), done, 1);
    checkOutput($sformatf("%s.busyEnd", tag), busy, 0);
    checkOutput($sformatf("%s.hilo", tag), {hi, lo}, expected);
  endtask

  initial begin
    logic [63:0] expected;
    logic [31:0] loBefore;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          cnt, waited;
    logic        stallInit;

    rst = 1'b1; start = 1'b0; op = 3'd0; srcA = '0; srcB = '0;
    readReq = 1'b1; flush = 1'b0;
    tick();
    tick();
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.stall", stall, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    readReq = 1'b0;
    tick();

    $display("[TB] directed mul/div cases");
    runOp(MD_MULT,  32'd7,          32'hFFFF_FFFD, "mult7xm3");
    runOp(MD_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, "multuMax");
    runOp(MD_DIV,   32'hFFFF_FFF9,  32'd2,         "divm7by2");
    runOp(MD_DIVU,  32'd100,        32'd7,         "divu100by7");
    runOp(MD_DIVU,  32'd5,          32'd0,         "divu5by0");
    runOp(MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF, "divMinByM1");
    runOp(MD_DIV,   32'hFFFF_FFFB,  32'd0,         "divm5by0");
    runOp(MD_MULT,  32'h8000_0000,  32'h8000_0000, "multMinMin");

    $display("[TB] MTHI/MTLO and ignored ops");
    applyStimulus(MD_MTHI, 32'hABCD_0001, 32'd0);
    tick();
    applyStimulus(MD_MTLO, 32'h1357_2468, 32'd0);
    tick();
    start = 1'b0;
    checkOutput("mthimtlo.hilo", {hi, lo}, {32'hABCD_0001, 32'h1357_2468});
    checkOutput("mthimtlo.busy", busy, 0);
    applyStimulus(3'd6, 32'hDEAD_BEEF, 32'd3);
    tick();
    applyStimulus(3'd7, 32'hDEAD_BEEF, 32'd3);
    tick();
    start = 1'b0;
    checkOutput("noop.busy", busy, 0);
    checkOutput("noop.hilo", {hi, lo}, {32'hABCD_0001, 32'h1357_2468});

    $display("[TB] stall on read_req during MULT");
    expected = refModel(MD_MULT, 32'h0001_2345, 32'hFFFF_0010);
    applyStimulus(MD_MULT, 32'h0001_2345, 32'hFFFF_0010);
    tick();
    start = 1'b0;
    tick();
    tick();
    readReq = 1'b1;
    cnt = 0;
    for (int k = 3; k <= 32; k++) begin
      tick();
      if (stall) cnt++;
    end
    checkOutput("readStall.window", cnt, 30);
    tick();
    checkOutput("readStall.afterDone", stall, 0);
    checkOutput("readStall.done", done, 1);
    checkOutput("readStall.hilo", {hi, lo}, expected);
    readReq = 1'b0;

    $display("[TB] MTLO issued while busy");
    expected = refModel(MD_MULTU, 32'h00FF_00FF, 32'h0000_1001);
    applyStimulus(MD_MULTU, 32'h00FF_00FF, 32'h0000_1001);
    tick();
    applyStimulus(MD_MTLO, 32'hCAFE_F00D, 32'd0);
    #1;
    stallInit = stall;
    waited = 0;
    while (stall && waited < 40) begin
      tick();
      waited++;
    end
    checkOutput("mtloBusy.stallInit", stallInit, 1);
    checkOutput("mtloBusy.waited", waited, 33);
    checkOutput("mtloBusy.mulResult", {hi, lo}, expected);
    tick();
    start = 1'b0;
    checkOutput("mtloBusy.hilo", {hi, lo}, {expected[63:32], 32'hCAFE_F00D});
    checkOutput("mtloBusy.busy", busy, 0);

    $display("[TB] reset mid DIV");
    applyStimulus(MD_DIV, 32'h7FFF_FFFF, 32'd3);
    tick();
    start = 1'b0;
    repeat (9) tick();
    readReq = 1'b1;
    #2 rst = 1'b1;
    #1;
    checkOutput("midReset.busy", busy, 0);
    checkOutput("midReset.stall", stall, 0);
    checkOutput("midReset.hilo", {hi, lo}, 64'd0);
    #1 rst = 1'b0;
    readReq = 1'b0;
    tick();
    checkOutput("midReset.after", {busy, done}, 0);

    $display("[TB] flush cases");
    applyStimulus(MD_MTHI, 32'h0000_1234, 32'd0);
    tick();
    applyStimulus(MD_MTLO, 32'h0000_5678, 32'd0);
    tick();
    loBefore = lo;
    applyStimulus(MD_MULT, 32'd1000, 32'd1000);
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flushRun.busy", busy, 0);
    checkOutput("flushRun.hilo", {hi, lo}, {32'h0000_1234, loBefore});
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done) cnt++;
    end
    checkOutput("flushRun.noDone", cnt, 0);

    applyStimulus(MD_DIVU, 32'd99, 32'd4);
    tick();
    start = 1'b0;
    repeat (32) tick();
    checkOutput("flushFix.busyInFix", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flushFix.doneBusy", {done, busy}, 0);
    checkOutput("flushFix.hilo", {hi, lo}, {32'h0000_1234, loBefore});

    applyStimulus(MD_MTHI, 32'h5555_5555, 32'd0);
    flush = 1'b1;
    tick();
    applyStimulus(MD_MULT, 32'd3, 32'd4);
    tick();
    start = 1'b0;
    flush = 1'b0;
    checkOutput("flushIdle.hi", hi, 32'h0000_1234);
    checkOutput("flushIdle.busy", busy, 0);

    $display("[TB] randomized back-to-back operations");
    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 255));
      runOp(rop, ra, rb, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Decode/issue drives it for MULT/MULTU/DIV/DIVU/MTHI/MTLO, and it stalls the front end on MFHI/MFLO while an operation is in flight.
- Computes iteratively: one bit per cycle (shift-add multiply, restoring divide), with a sign-fixup cycle.
- Sits beside the ALU in execute and feeds HI/LO to the register-write mux.

Parameters:
- XLEN, 32, operand and HI/LO width.
- ITERS, 32, iteration cycles per mul/div; must equal XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  issue request, qualified by op.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are ignored (no-op).
- src_a  input  XLEN  rs value: multiplicand or dividend; MTHI/MTLO data.
- src_b  input  XLEN  rt value: multiplier or divisor.
- read_req  input  1  decode holds MFHI or MFLO this cycle.
- flush  input  1  abandon the in-flight operation (pipeline squash).
- busy  output  1  operation in flight.
- stall  output  1  hold the issue/decode stage.
- done  output  1  one-cycle pulse when HI/LO are updated by mul/div.
- hi  output  XLEN  HI register.
- lo  output  XLEN  LO register.

Behaviour:
Clock and reset:
- One clock, clk.
- rst is asynchronous and active-high.
- Reset values: state IDLE, busy=0, stall=0, done=0, hi=0, lo=0, all internal accumulators and counters 0.
- Reset asserted mid-operation aborts the operation immediately. HI/LO return to 0.

States:
- IDLE, RUN, FIX.

IDLE:
- start with op 0-3: latch |src_a|, |src_b| (raw values for the unsigned ops).
- Latch neg_res = sign(a) XOR sign(b) and neg_rem = sign(a); both are 0 for unsigned ops.
- Load count=ITERS-1 and go to RUN. busy=1 from the next cycle.
- start with op 4 or 5: write hi or lo from src_a at that edge and stay IDLE. No done pulse.

RUN, multiply:
- Each cycle: if multiplier LSB is set, add the multiplicand to the upper half of the 2*XLEN accumulator with carry-out kept.
- Then shift right 1.

RUN, divide:
- Each cycle: shift the {rem,quo} pair left 1, trial-subtract the divisor from rem.
- If non-negative, keep the result and set the quo LSB.
- count decrements each cycle. At count==0, go to FIX.

FIX (1 cycle):
- If neg_res, two's-complement negate the product (mul) or quotient (div).
- If neg_rem, negate the remainder.
- mul: hi=product[2*XLEN-1:XLEN], lo=product[XLEN-1:0].
- div: lo=quotient, hi=remainder.
- done=1 for this cycle only, then IDLE with busy=0.

Latency:
- start at edge 0 → HI/LO valid and done high after edge ITERS+1 (33 cycles).
- A back-to-back start is accepted in the cycle following done.

Stall:
- stall = busy AND (read_req OR start).
- Combinational; it drops in the cycle after FIX.
- start while busy is ignored; issue must hold it until stall drops.
- MFHI/MFLO never read a partial result.

Boundary cases:
- Divide by zero, all variants: no sign fixup. Result lo=32'hFFFFFFFF, hi=src_a as issued.
- Divide by zero keeps the full latency.
- DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0, no trap.
- Magnitude of 32'h80000000 is 32'h80000000, treated as unsigned. The result stays correct.

Flush:
- flush in RUN or FIX: go to IDLE next edge. HI/LO are unchanged and done is not pulsed.
- flush takes priority over FIX completion on the same edge.
- flush together with start in IDLE: the start is dropped.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings MD_MULT..MD_MTLO,
  - the state encoding (IDLE/RUN/FIX),
  - the XLEN default.
- One sub-module, muldiv_iter_datapath, holds the accumulator/remainder registers, the adder/subtractor and the negators.
- The sequencer keeps the FSM, counter, sign flags, HI/LO and stall logic.

Test Plan:
- MULT 7 × 32'hFFFFFFFD (−3) → done at cycle 33, hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; busy high cycles 1-33.
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF → hi=32'hFFFFFFFE, lo=32'h00000001.
- DIV −7 / 2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU 100 / 7 → lo=14, hi=2.
- DIVU 5 / 0 → lo=32'hFFFFFFFF, hi=5. DIV 32'h80000000 / −1 → lo=32'h80000000, hi=0.
- read_req held from cycle 3 of a MULT → stall=1 through the FIX cycle, 0 the cycle after done. MTLO issued while busy → stall, then lo written once idle.
- rst pulse at cycle 10 of a DIV → immediate IDLE, hi=lo=0. flush at cycle 10 of a MULT after MTHI 32'h1234 → hi stays 32'h1234, no done.
